// File: rtl/mem_stage.sv
// Memory-access stage: ALU results pass through to writeback, loads/stores go out on a
// req/gnt/rvalid data bus with one outstanding access. ALU latency 1, load-to-wb 3+ cycles.
// Back-pressure: ex_ready_o is high only in IDLE.
module mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  reg_we_i,
    input  logic [4:0]            wr_addr_i,
    input  logic [31:0]           alu_result_i,
    input  logic [31:0]           store_data_i,
    input  logic [3:0]            lsu_op_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    output logic                  wb_we_o,
    output logic [4:0]            wb_addr_o,
    output logic [31:0]           wb_wdata_o,
    output logic                  misaligned_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t      state, state_next;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;

    logic        accept;
    logic        in_mem;
    logic        in_mis;
    logic        is_store;
    logic        is_load;
    logic        req;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign accept     = ex_valid_i && ex_ready_o;
    assign ex_ready_o = (state == IDLE);
    assign in_mem     = (lsu_op_i >= OP_LB) && (lsu_op_i <= OP_SW);
    assign is_store   = (op >= OP_SB) && (op <= OP_SW);
    assign is_load    = (op >= OP_LB) && (op <= OP_LHU);
    assign req        = (state == REQ);

    always_comb begin
        in_mis = 1'b0;
        case (lsu_op_i)
            OP_LH, OP_LHU, OP_SH: in_mis = alu_result_i[0];
            OP_LW, OP_SW:         in_mis = (alu_result_i[1:0] != 2'b00);
            default:              in_mis = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && in_mem && !in_mis) state_next = REQ;
            REQ:     if (data_gnt_i) state_next = RESP;
            RESP:    if (data_rvalid_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are driven from the registered instruction and forced to 0 outside REQ.
    always_comb begin
        data_req_o   = req;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_wdata_o = 32'h0;
        if (req) begin
            data_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00};
            data_we_o   = is_store;
            case (op)
                OP_SB: begin
                    data_be_o    = 4'b0001 << addr[1:0];
                    data_wdata_o = {4{sdata[7:0]}};
                end
                OP_SH: begin
                    data_be_o    = 4'b0011 << addr[1:0];
                    data_wdata_o = {2{sdata[15:0]}};
                end
                default: begin
                    data_be_o    = 4'hF;
                    data_wdata_o = sdata;
                end
            endcase
        end
    end

    always_comb begin
        case (addr[1:0])
            2'd0:    ld_byte = data_rdata_i[7:0];
            2'd1:    ld_byte = data_rdata_i[15:8];
            2'd2:    ld_byte = data_rdata_i[23:16];
            default: ld_byte = data_rdata_i[31:24];
        endcase
        ld_half = addr[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            op           <= 4'h0;
            addr         <= 32'h0;
            sdata        <= 32'h0;
            rd           <= 5'h0;
            wb_we_o      <= 1'b0;
            wb_addr_o    <= 5'h0;
            wb_wdata_o   <= 32'h0;
            misaligned_o <= 1'b0;
        end else begin
            state        <= state_next;
            wb_we_o      <= 1'b0;
            misaligned_o <= 1'b0;
            if (accept) begin
                op    <= lsu_op_i;
                addr  <= alu_result_i;
                sdata <= store_data_i;
                rd    <= wr_addr_i;
                if (in_mem) begin
                    misaligned_o <= in_mis;
                end else if (reg_we_i && (wr_addr_i != 5'd0)) begin
                    wb_we_o    <= 1'b1;
                    wb_addr_o  <= wr_addr_i;
                    wb_wdata_o <= alu_result_i;
                end
            end
            // wb address/data only move when a write actually happens
            if ((state == RESP) && data_rvalid_i && is_load && (rd != 5'd0)) begin
                wb_we_o    <= 1'b1;
                wb_addr_o  <= rd;
                wb_wdata_o <= ld_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage with a behavioural model of the
// expected bus transaction and writeback value for each instruction.
module tb_mem_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        reg_we_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [3:0]  lsu_op_i;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        wb_we_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_wdata_o;
    logic        misaligned_o;

    mem_stage #(.ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .reg_we_i(reg_we_i), .wr_addr_i(wr_addr_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .lsu_op_i(lsu_op_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_wdata_o(wb_wdata_o),
        .misaligned_o(misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int errors  = 0;
    logic [4:0]  mwb_addr = 5'h0;
    logic [31:0] mwb_data = 32'h0;
    logic [4:0]  pend_rd;
    logic [31:0] pend_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit is_mem(input int op);
        return (op >= 1) && (op <= 8);
    endfunction
    function automatic bit is_ld(input int op);
        return (op >= 1) && (op <= 5);
    endfunction
    function automatic bit is_st(input int op);
        return (op >= 6) && (op <= 8);
    endfunction
    function automatic bit misal(input int op, input logic [31:0] a);
        if (op == 2 || op == 5 || op == 7) return (a % 2) != 0;
        if (op == 3 || op == 8) return (a % 4) != 0;
        return 1'b0;
    endfunction
    function automatic logic [31:0] exp_be(input int op, input logic [31:0] a);
        if (op == 6) return 32'd1 << (a % 4);
        if (op == 7) return 32'd3 << (a % 4);
        return 32'd15;
    endfunction
    function automatic logic [31:0] exp_wd(input int op, input logic [31:0] s);
        if (op == 6) return (s & 32'hFF) * 32'h0101_0101;
        if (op == 7) return (s & 32'hFFFF) * 32'h0001_0001;
        return s;
    endfunction
    function automatic logic [31:0] exp_ld(input int op, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) & 32'hFF;
        h = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (op)
            1: return (b >= 128) ? b - 32'd256 : b;
            2: return (h >= 32768) ? h - 32'd65536 : h;
            4: return b;
            5: return h;
            default: return r;
        endcase
    endfunction

    // n ALU instructions on consecutive cycles; each writeback is expected one cycle later.
    task automatic alu_burst(input logic [4:0] rd, input logic [31:0] res, input bit we,
                             input logic [3:0] op, input int n);
        bit expw;
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                ex_valid_i = 1'b1; wr_addr_i = rd; alu_result_i = res + k;
                reg_we_i = we; lsu_op_i = op; store_data_i = $urandom;
                chk("alu_ready", ex_ready_o, 1);
            end else begin
                ex_valid_i = 1'b0;
            end
            if (k > 0) begin
                expw = we && (rd != 0);
                chk("alu_wb_we", wb_we_o, expw);
                if (expw) begin
                    mwb_addr = rd;
                    mwb_data = res + k - 1;
                end
                chk("alu_wb_addr", wb_addr_o, mwb_addr);
                chk("alu_wb_data", wb_wdata_o, mwb_data);
                chk("alu_mis", misaligned_o, 0);
            end
            step();
        end
    endtask

    task automatic mem_op(input int op, input logic [31:0] a, input logic [31:0] s,
                          input logic [4:0] rd, input int gd, input int rvd,
                          input logic [31:0] r, input bit hold);
        bit expw;
        ex_valid_i = 1'b1; lsu_op_i = 4'(op); alu_result_i = a;
        store_data_i = s; wr_addr_i = rd; reg_we_i = 1'b1;
        chk("mem_ready", ex_ready_o, 1);
        step();
        if (hold) begin
            lsu_op_i = 4'd0; wr_addr_i = pend_rd; alu_result_i = pend_res; reg_we_i = 1'b1;
        end else begin
            ex_valid_i = 1'b0;
        end
        if (misal(op, a)) begin
            chk("mis_pulse", misaligned_o, 1);
            chk("mis_req", data_req_o, 0);
            chk("mis_wb", wb_we_o, 0);
            chk("mis_ready", ex_ready_o, 1);
            if (!hold) begin
                step();
                chk("mis_once", misaligned_o, 0);
                chk("mis_req2", data_req_o, 0);
                chk("mis_wb2", wb_we_o, 0);
            end
            return;
        end
        chk("mem_mis", misaligned_o, 0);
        for (int i = 0; i <= gd; i++) begin
            chk("req", data_req_o, 1);
            chk("req_addr", data_addr_o, a & 32'hFFFF_FFFC);
            chk("req_be", data_be_o, exp_be(op, a));
            chk("req_we", data_we_o, is_st(op));
            if (is_st(op)) chk("req_wdata", data_wdata_o, exp_wd(op, s));
            chk("req_ready", ex_ready_o, 0);
            chk("req_wb", wb_we_o, 0);
            data_gnt_i    = (i == gd);
            data_rvalid_i = (i < gd) ? 1'($urandom % 2) : 1'b0;
            data_rdata_i  = $urandom;
            step();
        end
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        for (int j = 0; j <= rvd; j++) begin
            chk("resp_req", data_req_o, 0);
            chk("resp_ready", ex_ready_o, 0);
            chk("resp_wb", wb_we_o, 0);
            data_rvalid_i = (j == rvd);
            data_rdata_i  = (j == rvd) ? r : $urandom;
            step();
        end
        data_rvalid_i = 1'b0;
        chk("done_ready", ex_ready_o, 1);
        chk("done_req", data_req_o, 0);
        expw = is_ld(op) && (rd != 0);
        chk("ld_wb_we", wb_we_o, expw);
        if (expw) begin
            mwb_addr = rd;
            mwb_data = exp_ld(op, a, r);
        end
        chk("ld_wb_addr", wb_addr_o, mwb_addr);
        chk("ld_wb_data", wb_wdata_o, mwb_data);
    endtask

    initial begin
        rst_i = 1'b1; ex_valid_i = 1'b0; reg_we_i = 1'b0; wr_addr_i = 5'h0;
        alu_result_i = 32'h0; store_data_i = 32'h0; lsu_op_i = 4'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        step();
        step();
        chk("rst_ready", ex_ready_o, 1);
        chk("rst_req", data_req_o, 0);
        chk("rst_wb_we", wb_we_o, 0);
        chk("rst_wb_addr", wb_addr_o, 0);
        chk("rst_wb_data", wb_wdata_o, 0);
        chk("rst_mis", misaligned_o, 0);
        rst_i = 1'b0;

        alu_burst(5'd5, 32'h1234_5678, 1'b1, 4'd0, 3);
        alu_burst(5'd0, 32'h5555_0000, 1'b1, 4'd0, 3);
        alu_burst(5'd12, 32'h0BAD_0000, 1'b1, 4'd11, 2);

        mem_op(1, 32'h103, 32'h0, 5'd9, 2, 1, 32'h80FF_FFFF, 1'b0);
        chk("lb_value", wb_wdata_o, 32'hFFFF_FF80);
        mem_op(4, 32'h103, 32'h0, 5'd9, 2, 1, 32'h80FF_FFFF, 1'b0);
        chk("lbu_value", wb_wdata_o, 32'h0000_0080);
        mem_op(7, 32'h202, 32'hAAAA_BEEF, 5'd4, 0, 0, 32'hDEAD_BEEF, 1'b0);
        mem_op(3, 32'h101, 32'h0, 5'd6, 0, 0, 32'h0, 1'b0);
        mem_op(3, 32'h300, 32'h0, 5'd6, 0, 0, 32'hCAFE_F00D, 1'b0);
        chk("lw_value", wb_wdata_o, 32'hCAFE_F00D);

        // back-pressure: next ALU op held valid during a slow load
        pend_rd = 5'd7; pend_res = 32'hCAFE_0001;
        mem_op(3, 32'h500, 32'h0, 5'd8, 0, 5, 32'h1122_3344, 1'b1);
        step();
        ex_valid_i = 1'b0;
        chk("bp_wb_we", wb_we_o, 1);
        chk("bp_wb_addr", wb_addr_o, 7);
        chk("bp_wb_data", wb_wdata_o, 32'hCAFE_0001);
        step();
        chk("bp_no_dup", wb_we_o, 0);

        // reset while a request is pending
        ex_valid_i = 1'b1; lsu_op_i = 4'd3; alu_result_i = 32'h400; wr_addr_i = 5'd3; reg_we_i = 1'b1;
        step();
        ex_valid_i = 1'b0;
        chk("pre_rst_req", data_req_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mwb_addr = 5'h0; mwb_data = 32'h0;
        chk("mid_rst_req", data_req_o, 0);
        chk("mid_rst_ready", ex_ready_o, 1);
        chk("mid_rst_be", data_be_o, 0);
        chk("mid_rst_addr", data_addr_o, 0);
        chk("mid_rst_wb_addr", wb_addr_o, 0);
        chk("mid_rst_wb_data", wb_wdata_o, 0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h7777_7777;
        step();
        data_rvalid_i = 1'b0;
        chk("stale_rv_wb", wb_we_o, 0);
        chk("stale_rv_req", data_req_o, 0);
        chk("stale_rv_ready", ex_ready_o, 1);

        for (int it = 0; it < 60; it++) begin
            int op;
            logic [31:0] a;
            op = int'($urandom % 16);
            a  = $urandom;
            if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
            if (is_mem(op))
                mem_op(op, a, $urandom, 5'($urandom % 32), int'($urandom % 3),
                       int'($urandom % 3), $urandom, 1'b0);
            else
                alu_burst(5'($urandom % 32), a, 1'($urandom % 2), 4'(op), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
